mem_pwm: RTL and testbench
==========================

# mem_pwm

Memory-mapped multi-channel PWM peripheral on the SoC `iomem` bus. It sits downstream of the top-level `iomem` address decode at its own 64 KiB window, `iomem_addr[31:16] == 16'h0301`. It also sits upstream of `mem_gpio`: its `pwm_oe`/`pwm_do` outputs drive the `alt_oe`/`alt_do` lanes of selected pins. All channels share one 16-bit prescaled counter. Each channel compares the counter against its own double-buffered duty value.

## Interface
- `NCH`, default 4: number of PWM channels (1–8).
- `CNT_W`, default 16: counter, period and duty width.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset; one clock; reset is synchronous and active-low.
- `mem_valid` in 1: request, already address-decoded upstream.
- `mem_ready` out 1: single-cycle acknowledge.
- `mem_addr` in 32: byte address; only `[5:2]` used.
- `mem_rdata` out 32: read data, valid when `mem_ready`=1.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte enables; 0 means read.
- `pwm_oe` out NCH: per-channel output enable toward `mem_gpio` `alt_oe`.
- `pwm_do` out NCH: per-channel PWM level toward `mem_gpio` `alt_do`.
- `irq` out 1: level interrupt (see Configuration).

## Operation
Registers (word offset, all reset to 0):
- 0x00 CTRL: [0] EN; [8+NCH-1:8] CH_EN; [16] IRQ_EN.
- 0x04 PRESCALE: [CNT_W-1:0]. A tick occurs every PRESCALE+1 clocks.
- 0x08 PERIOD: [CNT_W-1:0], shadow register. The counter runs 0..PERIOD.
- 0x0C STATUS: [0] WRAP flag, write-1-to-clear; [31:16] current counter, read-only.
- 0x10+4·i DUTY[i]: [CNT_W-1:0], shadow register. Offsets beyond NCH read 0 and ignore writes.

Bus behaviour:
- Writes honour `mem_wstrb` per byte. Unused bits read 0.

Counter and shadow registers:
- While EN=1, on each tick the counter increments. When it equals active PERIOD it wraps to 0.
- At a wrap, the WRAP flag is set and shadow PERIOD/DUTY are copied to the active copies.
- While EN=0, the prescaler and counter are held at 0 and shadows copy to active every clock.

Channel output:
- `pwm_do[i]` = EN & CH_EN[i] & (counter < active DUTY[i]), registered.
- DUTY=0 gives constant low. DUTY > PERIOD gives constant high.
- `pwm_oe[i]` = EN & CH_EN[i], registered.

Boundary cases:
- PERIOD=0: wraps every tick; WRAP is set every tick.
- PRESCALE=0: one tick per clock.
- A WRAP set and a W1C clear in the same cycle: set wins.
- Writing EN 1→0 mid-period: counter → 0 and outputs low on the next clock. No WRAP is generated.
- Reset mid-transaction: `mem_ready` drops. The pending request is discarded and the master re-issues it.

## Timing
- Bus handshake:
  - `mem_ready` rises exactly 1 clock after `mem_valid` is first seen, and stays high for one clock.
  - `mem_rdata` is registered and valid in that same cycle.
  - The master holds `mem_valid` and the address until `mem_ready`.
  - An internal busy flag blocks re-acknowledging the same request; the next request is accepted no earlier than the cycle after `mem_ready`.
- A register write takes effect on the clock edge that raises `mem_ready`.
- `pwm_do` lags the counter by 1 clock.
- Output period is (PRESCALE+1)·(PERIOD+1) clocks. High time is (PRESCALE+1)·min(DUTY, PERIOD+1) clocks.
- Reset values: `mem_ready`=0, `mem_rdata`=0, `pwm_oe`=0, `pwm_do`=0, `irq`=0, counter=0, prescaler=0.

## Configuration
- `MEM_PWM_IRQ_EN` defined: `irq` = WRAP & IRQ_EN, registered, 1 clock after WRAP sets.
- `MEM_PWM_IRQ_EN` undefined: `irq` is tied 0, the CTRL[16] IRQ_EN bit reads 0 and ignores writes, and the WRAP flag still functions.

## Structure
- Package `mem_pwm_pkg` holds:
  - register offset constants (CTRL, PRESCALE, PERIOD, STATUS, DUTY base);
  - CTRL bit positions;
  - the default CNT_W.
- Sub-module `pwm_channel` is instantiated NCH times. It contains the shadow and active duty registers, the comparator and the registered output. The top level keeps the bus logic, prescaler, counter and WRAP/irq.

## Test plan
- Reset: hold `rstn`=0 for 2 clocks, then read CTRL and STATUS → both 0. `pwm_oe`=0, `pwm_do`=0, `irq`=0.
- Basic PWM:
  - Setup: PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=0x101.
  - Required: `pwm_do[0]` high 3 clocks, low 7, period 10.
  - Required: `pwm_oe[0]`=1, `pwm_oe[1]`=0.
- Shadow update: write DUTY0=7 mid-period → the old duty completes the current period, and the new 7/10 duty starts at counter 0.
- Extremes and prescale:
  - DUTY0=0 → constant low; DUTY0=12 with PERIOD=9 → constant high.
  - PRESCALE=3 → period 40 clocks.
- WRAP and IRQ (`MEM_PWM_IRQ_EN` defined):
  - With IRQ_EN=1, `irq` rises after the first wrap.
  - W1C write of 0x1 to STATUS on the same cycle as the next wrap → WRAP remains 1.
- Bus handshake:
  - Back-to-back reads with `mem_valid` held high → exactly one `mem_ready` pulse per request.
  - A byte write with `mem_wstrb`=4'b0010 to PERIOD leaves bits [7:0] unchanged.

Source files
------------

// File: rtl/mem_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pwm_pkg
// Description : Register map, CTRL bit positions and defaults for mem_pwm.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pwm_pkg;

  localparam int CNT_W_DEF = 16;

  // Word index of each register, i.e. byte offset >> 2 (mem_addr[5:2]).
  typedef enum logic [3:0] {
    REG_CTRL     = 4'h0,
    REG_PRESCALE = 4'h1,
    REG_PERIOD   = 4'h2,
    REG_STATUS   = 4'h3
  } reg_idx_e;

  localparam logic [3:0] REG_DUTY_BASE = 4'h4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CH_EN_LSB  = 8;
  localparam int CTRL_IRQ_EN_BIT = 16;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM lane: shadow/active duty, comparator, registered out.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
  import mem_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic [CNT_W-1:0] i_wmask,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_do,
  output logic             o_oe
);

  logic [CNT_W-1:0] r_duty_sh;
  logic [CNT_W-1:0] r_duty_act;
  logic             r_do;
  logic             r_oe;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_duty_sh  <= '0;
      r_duty_act <= '0;
      r_do       <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      if (i_wr) begin
        r_duty_sh <= (r_duty_sh & ~i_wmask) | (i_wdata & i_wmask);
      end
      if (i_load) begin
        r_duty_act <= r_duty_sh;
      end
      r_do <= i_en & (i_cnt < r_duty_act);
      r_oe <= i_en;
    end
  end

  assign o_duty = r_duty_sh;
  assign o_do   = r_do;
  assign o_oe   = r_oe;

endmodule
`default_nettype wire

// File: rtl/mem_pwm.sv
`default_nettype none
// ============================================================================
// Module      : mem_pwm
// Description : iomem-mapped multi-channel PWM with shared prescaled counter.
//               Optional macro MEM_PWM_IRQ_EN enables the wrap interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_pwm
  import mem_pwm_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           mem_valid,
  output logic           mem_ready,
  input  logic [31:0]    mem_addr,
  output logic [31:0]    mem_rdata,
  input  logic [31:0]    mem_wdata,
  input  logic [3:0]     mem_wstrb,
  output logic [NCH-1:0] pwm_oe,
  output logic [NCH-1:0] pwm_do,
  output logic           irq
);

  logic                       r_ready;
  logic [31:0]                r_rdata;
  logic                       r_en;
  logic [NCH-1:0]             r_chen;
  logic [CNT_W-1:0]           r_prescale;
  logic [CNT_W-1:0]           r_period_sh;
  logic [CNT_W-1:0]           r_period_act;
  logic [CNT_W-1:0]           r_pre;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_wrap;

  logic                       w_accept;
  logic                       w_wr;
  logic [31:0]                w_mask;
  logic [31:0]                w_rdata;
  logic [CNT_W-1:0]           w_wmask_c;
  logic [CNT_W-1:0]           w_wdata_c;
  logic [3:0]                 w_idx;
  logic                       w_tick;
  logic                       w_wrap;
  logic                       w_load;
  logic                       w_w1c;
  logic [NCH:0][CNT_W-1:0]    w_duty_or;
  logic                       w_unused;

  // r_ready doubles as the busy flag: a held request is not re-acknowledged.
  assign w_accept  = mem_valid & ~r_ready;
  assign w_wr      = w_accept & (|mem_wstrb);
  assign w_mask    = strb_mask(mem_wstrb);
  assign w_wmask_c = w_mask[CNT_W-1:0];
  assign w_wdata_c = mem_wdata[CNT_W-1:0];
  assign w_idx     = mem_addr[5:2];

  assign w_tick = r_en & (r_pre >= r_prescale);
  assign w_wrap = w_tick & (r_cnt == r_period_act);
  assign w_load = w_wrap | ~r_en;
  assign w_w1c  = w_wr & (w_idx == REG_STATUS) & w_mask[0] & mem_wdata[0];

  assign w_unused = &{1'b0, mem_addr, mem_wdata, w_mask};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ready      <= 1'b0;
      r_rdata      <= '0;
      r_en         <= 1'b0;
      r_chen       <= '0;
      r_prescale   <= '0;
      r_period_sh  <= '0;
      r_period_act <= '0;
      r_pre        <= '0;
      r_cnt        <= '0;
      r_wrap       <= 1'b0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) begin
        r_rdata <= w_rdata;
      end
      if (w_wr && (w_idx == REG_CTRL)) begin
        if (w_mask[CTRL_EN_BIT]) begin
          r_en <= mem_wdata[CTRL_EN_BIT];
        end
        r_chen <= (r_chen & ~w_mask[CTRL_CH_EN_LSB +: NCH])
                | (mem_wdata[CTRL_CH_EN_LSB +: NCH] & w_mask[CTRL_CH_EN_LSB +: NCH]);
      end
      if (w_wr && (w_idx == REG_PRESCALE)) begin
        r_prescale <= (r_prescale & ~w_wmask_c) | (w_wdata_c & w_wmask_c);
      end
      if (w_wr && (w_idx == REG_PERIOD)) begin
        r_period_sh <= (r_period_sh & ~w_wmask_c) | (w_wdata_c & w_wmask_c);
      end
      if (w_load) begin
        r_period_act <= r_period_sh;
      end
      if (!r_en) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else if (w_tick) begin
        r_pre <= '0;
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      // A wrap in the same cycle as a clear keeps the flag set.
      if (w_wrap) begin
        r_wrap <= 1'b1;
      end else if (w_w1c) begin
        r_wrap <= 1'b0;
      end
    end
  end

`ifdef MEM_PWM_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_idx == REG_CTRL) && w_mask[CTRL_IRQ_EN_BIT]) begin
        r_irq_en <= mem_wdata[CTRL_IRQ_EN_BIT];
      end
      r_irq <= r_wrap & r_irq_en;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign w_duty_or[0] = '0;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic             w_hit;
      logic [CNT_W-1:0] w_duty;

      assign w_hit = (w_idx == (REG_DUTY_BASE + 4'(i)));

      pwm_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk     (clk),
        .rstn    (rstn),
        .i_wr    (w_wr & w_hit),
        .i_wdata (w_wdata_c),
        .i_wmask (w_wmask_c),
        .i_load  (w_load),
        .i_en    (r_en & r_chen[i]),
        .i_cnt   (r_cnt),
        .o_duty  (w_duty),
        .o_do    (pwm_do[i]),
        .o_oe    (pwm_oe[i])
      );

      assign w_duty_or[i+1] = w_duty_or[i] | (w_hit ? w_duty : '0);
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL: begin
        w_rdata[CTRL_EN_BIT]             = r_en;
        w_rdata[CTRL_CH_EN_LSB +: NCH]   = r_chen;
`ifdef MEM_PWM_IRQ_EN
        w_rdata[CTRL_IRQ_EN_BIT]         = r_irq_en;
`endif
      end
      REG_PRESCALE: w_rdata[CNT_W-1:0] = r_prescale;
      REG_PERIOD:   w_rdata[CNT_W-1:0] = r_period_sh;
      REG_STATUS: begin
        w_rdata[0]          = r_wrap;
        w_rdata[16 +: CNT_W] = r_cnt;
      end
      default:      w_rdata[CNT_W-1:0] = w_duty_or[NCH];
    endcase
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_pwm
// Description : Randomized self-checking bench for mem_pwm against a
//               duty/period arithmetic model. Honors MEM_PWM_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_pwm;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;

`ifdef MEM_PWM_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam logic [31:0] A_CTRL   = 32'h0301_0000;
  localparam logic [31:0] A_PRE    = 32'h0301_0004;
  localparam logic [31:0] A_PERIOD = 32'h0301_0008;
  localparam logic [31:0] A_STATUS = 32'h0301_000C;
  localparam logic [31:0] A_DUTY0  = 32'h0301_0010;

  logic           clk = 1'b0;
  logic           rstn;
  logic           mem_valid;
  logic           mem_ready;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_rdata;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wstrb;
  logic [NCH-1:0] pwm_oe;
  logic [NCH-1:0] pwm_do;
  logic           irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_pwm #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .pwm_oe    (pwm_oe),
    .pwm_do    (pwm_do),
    .irq       (irq)
  );

  // Per-cycle history of channel 0 output and irq.
  bit h_do  [65536];
  bit h_irq [65536];
  int cyc = 0;

  always @(posedge clk) begin
    #1;
    if (cyc < 65536) begin
      h_do[cyc]  = pwm_do[0];
      h_irq[cyc] = irq;
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rdat);
    int k;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = ws;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!mem_ready && k < 10);
    check("bus_latency", k, 1);
    rdat      = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check("bus_ready_pulse", {31'b0, mem_ready}, 0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(addr, wd, 4'hF, dummy);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] rdat);
    bus(addr, 32'h0, 4'h0, rdat);
  endtask

  // Reference: the steady-state waveform repeats every (P+1)(N+1) clocks and
  // is high for (P+1)*min(D,N+1) of them, as one contiguous run.
  task automatic measure(input string tag, input int p, input int n, input int d);
    int len, hi, rises, bad, s, exp_hi, exp_rises, dm;
    len = (p + 1) * (n + 1);
    repeat (3 * len + 4) @(posedge clk);
    #1;
    s = cyc - 2 - 2 * len;
    hi = 0; rises = 0; bad = 0;
    for (int k = 0; k < len; k++) begin
      if (h_do[s + len + k]) hi++;
      if (h_do[s + len + k] && !h_do[s + len + k - 1]) rises++;
      if (h_do[s + k] != h_do[s + k + len]) bad++;
    end
    dm        = (d < n + 1) ? d : n + 1;
    exp_hi    = (p + 1) * dm;
    exp_rises = (d > 0 && d <= n) ? 1 : 0;
    check($sformatf("%s_high", tag), hi, exp_hi);
    check($sformatf("%s_rises", tag), rises, exp_rises);
    check($sformatf("%s_periodic", tag), bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int p, n, d;
    int k, pulses, dbl, ones;
    int idx0, a, b, c;
    bit prev, cur, found, prevr;

    rstn      = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, mem_ready}, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_oe", {28'b0, pwm_oe}, 0);
    check("rst_do", {28'b0, pwm_do}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    rd(A_CTRL, r);   check("rst_ctrl", r, 0);
    rd(A_STATUS, r); check("rst_status", r, 0);

    // Basic 3/10 waveform on channel 0 only.
    wr(A_PRE, 0);
    wr(A_PERIOD, 9);
    wr(A_DUTY0, 3);
    wr(A_CTRL, 32'h101);
    measure("basic", 0, 9, 3);
    check("basic_oe", {28'b0, pwm_oe}, 32'h1);
    rd(A_CTRL, r);  check("ctrl_rb", r, 32'h101);
    rd(A_DUTY0, r); check("duty0_rb", r, 3);

    // Shadow duty: change just after a falling edge.
    prev = pwm_do[0]; k = 0; found = 1'b0;
    do begin
      @(posedge clk); #1;
      k++;
      cur   = pwm_do[0];
      found = prev && !cur;
      prev  = cur;
    end while (!found && k < 40);
    check("shadow_fall_seen", {31'b0, found}, 1);
    idx0 = cyc;
    wr(A_DUTY0, 7);
    repeat (30) @(posedge clk);
    #1;
    a = -1; b = -1; c = -1;
    for (int j = idx0 - 3; j < cyc - 2; j++) begin
      if (a < 0) begin
        if (h_do[j-1] && !h_do[j]) a = j;
      end else if (b < 0) begin
        if (!h_do[j-1] && h_do[j]) b = j;
      end else if (c < 0) begin
        if (h_do[j-1] && !h_do[j]) c = j;
      end
    end
    check("shadow_old_low", b - a, 7);
    check("shadow_new_high", c - b, 7);

    // Extremes and prescale.
    wr(A_DUTY0, 0);
    measure("duty_zero", 0, 9, 0);
    wr(A_DUTY0, 12);
    measure("duty_over", 0, 9, 12);
    wr(A_DUTY0, 3);
    wr(A_PRE, 3);
    measure("prescale3", 3, 9, 3);

    // Randomized configurations.
    for (int it = 0; it < 6; it++) begin
      p = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 12));
      d = int'($urandom_range(0, n + 3));
      wr(A_CTRL, 0);
      wr(A_PRE, p);
      wr(A_PERIOD, n);
      wr(A_DUTY0, d);
      wr(A_CTRL, 32'h101);
      measure($sformatf("rand%0d_p%0d_n%0d_d%0d", it, p, n, d), p, n, d);
    end

    // Held mem_valid: one acknowledge per request, never two in a row.
    mem_addr  = A_CTRL;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    pulses = 0; dbl = 0; prevr = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
      if (mem_ready && prevr) dbl++;
      prevr = mem_ready;
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_pulses", pulses, 4);
    check("hold_back2back", dbl, 0);
    check("hold_rdata", mem_rdata, 32'h101);

    // Byte strobe and unimplemented duty slots.
    wr(A_PERIOD, 32'h1234);
    bus(A_PERIOD, 32'h0000_ABCD, 4'b0010, r);
    rd(A_PERIOD, r); check("period_byte1", r, 32'hAB34);
    wr(A_DUTY0 + 4 * NCH, 32'hFFFF);
    rd(A_DUTY0 + 4 * NCH, r); check("duty_oob", r, 0);
    rd(32'h0301_003C, r); check("reg_3c", r, 0);

    // WRAP flag and irq.
    wr(A_CTRL, 0);
    wr(A_PRE, 0);
    wr(A_PERIOD, 0);
    wr(A_STATUS, 1);
    rd(A_STATUS, r); check("wrap_cleared", r, 0);
    check("irq_idle", {31'b0, irq}, 0);
    wr(A_CTRL, 32'h10101);
    repeat (4) @(posedge clk);
    #1;
    rd(A_STATUS, r); check("wrap_period0", r, 1);
    check("irq_on_wrap", {31'b0, irq}, {31'b0, IRQ_ON});
    rd(A_CTRL, r); check("ctrl_irq_en", r, IRQ_ON ? 32'h10101 : 32'h101);
    // PERIOD=0 wraps every clock, so this clear collides with a wrap.
    wr(A_STATUS, 1);
    repeat (5) @(posedge clk);
    #1;
    ones = 0;
    for (int j = cyc - 10; j < cyc - 2; j++) if (h_irq[j]) ones++;
    check("w1c_collision_irq", ones, IRQ_ON ? 8 : 0);
    rd(A_STATUS, r); check("w1c_collision_flag", r & 32'h1, 1);

    wr(A_CTRL, 0);
    wr(A_PERIOD, 50);
    wr(A_DUTY0, 32'hFFFF);
    wr(A_STATUS, 1);
    wr(A_CTRL, 32'h10101);
    rd(A_STATUS, r); check("status_after_en", r, 32'h0001_0000);
    check("irq_after_clear", {31'b0, irq}, 0);
    repeat (60) @(posedge clk);
    #1;
    rd(A_STATUS, r); check("wrap_period50", r & 32'h1, 1);
    check("irq_period50", {31'b0, irq}, {31'b0, IRQ_ON});
    check("do_full_duty", {31'b0, pwm_do[0]}, 1);

    // Disable mid-period.
    wr(A_STATUS, 1);
    wr(A_CTRL, 0);
    check("off_oe", {28'b0, pwm_oe}, 0);
    check("off_do", {28'b0, pwm_do}, 0);
    rd(A_STATUS, r); check("off_status", r, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
